// File: rtl/etch_pen_ctrl_if.sv
// ---------------------------------------------------------------------------
// etch_pen_ctrl_if
//   Bundles the button/clear inputs and the video-RAM write port of the
//   etch-a-sketch pen controller.
//
//   Signals
//     up_lvl/down_lvl/left_lvl/right_lvl  debounced direction button levels
//     clr_req                             one-cycle bitmap erase request
//     pen_color [2:0]                     colour painted at the pen
//     pen_x/pen_y [COORD_W-1:0]           current pen column/row
//     we                                  RAM write enable
//     addr_w [2*COORD_W-1:0]              RAM write address {row, column}
//     din [2:0]                           RAM write data
//     busy                                clear sweep in progress
//
//   Modports
//     master  the side that drives buttons and observes the write port
//     slave   the pen controller itself
// ---------------------------------------------------------------------------
interface etch_pen_ctrl_if #(
    parameter int COORD_W = 7
);
    logic                   up_lvl;
    logic                   down_lvl;
    logic                   left_lvl;
    logic                   right_lvl;
    logic                   clr_req;
    logic [2:0]             pen_color;
    logic [COORD_W-1:0]     pen_x;
    logic [COORD_W-1:0]     pen_y;
    logic                   we;
    logic [2*COORD_W-1:0]   addr_w;
    logic [2:0]             din;
    logic                   busy;

    modport master (
        output up_lvl, down_lvl, left_lvl, right_lvl, clr_req, pen_color,
        input  pen_x, pen_y, we, addr_w, din, busy
    );

    modport slave (
        input  up_lvl, down_lvl, left_lvl, right_lvl, clr_req, pen_color,
        output pen_x, pen_y, we, addr_w, din, busy
    );
endinterface

// File: rtl/etch_pen_ctrl.sv
// ---------------------------------------------------------------------------
// etch_pen_ctrl
//   Pen/cursor controller feeding the write port of the etch-a-sketch video
//   RAM. Direction button levels become single steps on a press, then
//   auto-repeat steps while held; the pen is clamped to the bitmap. In DRAW
//   the pen colour is written at the pen every cycle; a clear request (or
//   reset) sweeps every address with BG_COLOR first.
//
//   Ports
//     clk    in   system clock, rising edge
//     reset  in   synchronous, active-high; restarts the clear sweep
//     bus    etch_pen_ctrl_if.slave: buttons, clr_req, pen_color in;
//            pen_x, pen_y, we, addr_w, din, busy out
// ---------------------------------------------------------------------------
module etch_pen_ctrl #(
    parameter int         COORD_W   = 7,
    parameter int         RPT_DELAY = 25_000_000,
    parameter int         RPT_RATE  = 2_500_000,
    parameter logic [2:0] BG_COLOR  = 3'b000
) (
    input  logic           clk,
    input  logic           reset,
    etch_pen_ctrl_if.slave bus
);

    localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int CNT_W   = $clog2(RPT_MAX + 1);
    localparam int ADDR_W  = 2 * COORD_W;

    localparam logic [COORD_W-1:0] POS_MAX    = '1;
    localparam logic [ADDR_W-1:0]  SWEEP_LAST = '1;
    localparam logic [CNT_W-1:0]   THR_DELAY  = CNT_W'(RPT_DELAY);
    localparam logic [CNT_W-1:0]   THR_RATE   = CNT_W'(RPT_RATE);

    // Direction indices into the per-button vectors.
    localparam int D_UP    = 0;
    localparam int D_DOWN  = 1;
    localparam int D_LEFT  = 2;
    localparam int D_RIGHT = 3;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_DRAW  = 1'b1
    } state_t;

    // Saturating one-position move; inc and dec never arrive together
    // because an axis conflict suppresses both steps.
    function automatic logic [COORD_W-1:0] step_axis(
        input logic [COORD_W-1:0] pos,
        input logic               inc,
        input logic               dec
    );
        logic [COORD_W-1:0] res;
        res = pos;
        if (inc && (pos != POS_MAX)) begin
            res = pos + 1'b1;
        end else if (dec && (pos != '0)) begin
            res = pos - 1'b1;
        end
        return res;
    endfunction

    state_t                      state_q, state_d;
    logic [ADDR_W-1:0]           sweep_q, sweep_d;
    logic [COORD_W-1:0]          pen_x_q, pen_x_d;
    logic [COORD_W-1:0]          pen_y_q, pen_y_d;
    logic [3:0]                  lvl;
    logic [3:0]                  conflict;
    logic [3:0]                  prev_q;
    logic [3:0]                  step;
    logic [3:0]                  rpt_q, rpt_d;
    logic [3:0][CNT_W-1:0]       cnt_q, cnt_d;

    assign lvl = {bus.right_lvl, bus.left_lvl, bus.down_lvl, bus.up_lvl};

    // Opposite buttons on one axis cancel each other out.
    assign conflict[D_UP]    = bus.up_lvl & bus.down_lvl;
    assign conflict[D_DOWN]  = bus.up_lvl & bus.down_lvl;
    assign conflict[D_LEFT]  = bus.left_lvl & bus.right_lvl;
    assign conflict[D_RIGHT] = bus.left_lvl & bus.right_lvl;

    // Per-direction step generation.
    // cnt counts cycles since the last step of that direction; cnt==0 means
    // "not armed", so a level already high when entering DRAW (or left over
    // after an axis conflict) never starts repeating without a fresh press.
    // rpt selects the initial delay or the repeat period as the threshold.
    always_comb begin
        step  = '0;
        cnt_d = cnt_q;
        rpt_d = rpt_q;
        for (int i = 0; i < 4; i++) begin
            if ((state_q != ST_DRAW) || !lvl[i] || conflict[i]) begin
                cnt_d[i] = '0;
                rpt_d[i] = 1'b0;
            end else if (!prev_q[i]) begin
                step[i]  = 1'b1;
                cnt_d[i] = CNT_W'(1);
                rpt_d[i] = 1'b0;
            end else if (cnt_q[i] != '0) begin
                if (cnt_q[i] == (rpt_q[i] ? THR_RATE : THR_DELAY)) begin
                    step[i]  = 1'b1;
                    cnt_d[i] = CNT_W'(1);
                    rpt_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        pen_x_d = step_axis(pen_x_q, step[D_RIGHT], step[D_LEFT]);
        pen_y_d = step_axis(pen_y_q, step[D_DOWN], step[D_UP]);
    end

    // Mode FSM: the sweep counter wraps to zero on its last address, so it
    // is already at 0 whenever DRAW hands back to CLEAR.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_CLEAR: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == SWEEP_LAST) begin
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                sweep_d = '0;
                if (bus.clr_req) begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                sweep_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            sweep_q <= '0;
            pen_x_q <= '0;
            pen_y_q <= '0;
            prev_q  <= '0;
            rpt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            pen_x_q <= pen_x_d;
            pen_y_q <= pen_y_d;
            // Tracks the levels in every state so a button held through a
            // sweep is not seen as a new press when DRAW resumes.
            prev_q  <= lvl;
            rpt_q   <= rpt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pen_x  = pen_x_q;
    assign bus.pen_y  = pen_y_q;
    assign bus.we     = 1'b1;
    assign bus.busy   = (state_q == ST_CLEAR);
    assign bus.addr_w = (state_q == ST_CLEAR) ? sweep_q : {pen_y_q, pen_x_q};
    assign bus.din    = (state_q == ST_CLEAR) ? BG_COLOR : bus.pen_color;

endmodule

// File: tb/tb_etch_pen_ctrl.sv
module tb_etch_pen_ctrl;

    localparam int         CW    = 3;
    localparam logic [2:0] COLOR = 3'b101;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    etch_pen_ctrl_if #(.COORD_W(CW)) bus ();

    etch_pen_ctrl #(
        .COORD_W  (CW),
        .RPT_DELAY(8),
        .RPT_RATE (4),
        .BG_COLOR (3'b000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step_clk();
        @(negedge clk);
    endtask

    // mask bits: 0 up, 1 down, 2 left, 3 right
    task automatic set_lvl(input logic [3:0] m);
        bus.up_lvl    = m[0];
        bus.down_lvl  = m[1];
        bus.left_lvl  = m[2];
        bus.right_lvl = m[3];
    endtask

    task automatic pulse(input logic [3:0] m);
        set_lvl(m);
        step_clk();
        set_lvl(4'b0000);
        step_clk();
    endtask

    task automatic check_pen(input string tag, input int x, input int y);
        check_vec({tag, "_x"},    32'(bus.pen_x), 32'(x));
        check_vec({tag, "_y"},    32'(bus.pen_y), 32'(y));
        check_vec({tag, "_addr"}, 32'(bus.addr_w), 32'(y * 8 + x));
        check_vec({tag, "_din"},  32'(bus.din), 32'(COLOR));
        check_vec({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_vec({tag, "_we"},   32'(bus.we), 32'd1);
    endtask

    // Starts at a cycle that should show address 0; ends at the first DRAW cycle.
    task automatic check_sweep(input string tag);
        for (int i = 0; i < 64; i++) begin
            check_vec({tag, "_addr"}, 32'(bus.addr_w), 32'(i));
            check_vec({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check_vec({tag, "_din"},  32'(bus.din), 32'd0);
            check_vec({tag, "_we"},   32'(bus.we), 32'd1);
            step_clk();
        end
    endtask

    // Hand-derived step count after t cycles of a continuous hold
    // (steps visible at t = 1, 9, 13, 17, ...).
    function automatic int held_steps(input int t);
        int e;
        e = (t >= 1) ? 1 : 0;
        if (t >= 9) e = e + 1 + (t - 9) / 4;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.clr_req   = 1'b0;
        bus.pen_color = COLOR;
        set_lvl(4'b0000);

        // 1. reset then full sweep
        step_clk();
        reset = 1'b0;
        check_vec("rst_pen_x", 32'(bus.pen_x), 32'd0);
        check_vec("rst_pen_y", 32'(bus.pen_y), 32'd0);
        check_sweep("sweep1");
        check_pen("draw0", 0, 0);

        // 2. single press right
        pulse(4'b1000);
        check_pen("press_r", 1, 0);
        step_clk();
        check_pen("press_r_hold", 1, 0);

        // 3. hold right from (0,0): repeat and clamp at 7
        pulse(4'b0100);
        check_pen("back_l", 0, 0);
        set_lvl(4'b1000);
        for (int t = 1; t <= 30; t++) begin
            int e;
            step_clk();
            e = held_steps(t);
            if (e > 7) e = 7;
            check_vec("hold_r_x", 32'(bus.pen_x), 32'(e));
        end
        set_lvl(4'b0000);
        step_clk();
        check_pen("hold_r_end", 7, 0);

        // hold left back down to 0 (clamp at 0)
        set_lvl(4'b0100);
        for (int t = 1; t <= 30; t++) begin
            int e;
            step_clk();
            e = held_steps(t);
            if (e > 7) e = 7;
            check_vec("hold_l_x", 32'(bus.pen_x), 32'(7 - e));
        end
        set_lvl(4'b0000);
        step_clk();
        check_pen("hold_l_end", 0, 0);

        // 4. left+up at origin, then up&down conflict
        pulse(4'b0101);
        check_pen("lu_origin", 0, 0);
        pulse(4'b0010);
        pulse(4'b0010);
        check_pen("down2", 0, 2);
        set_lvl(4'b0011);
        for (int t = 1; t <= 20; t++) begin
            step_clk();
            check_vec("ud_conflict_y", 32'(bus.pen_y), 32'd2);
        end
        set_lvl(4'b0000);
        step_clk();
        check_pen("ud_end", 0, 2);
        pulse(4'b1010);
        check_pen("diag", 1, 3);
        for (int k = 0; k < 4; k++) pulse(4'b1000);
        check_pen("pen53", 5, 3);

        // 5. clear request; buttons and clr_req ignored mid-sweep
        bus.clr_req = 1'b1;
        step_clk();
        bus.clr_req = 1'b0;
        for (int i = 0; i < 64; i++) begin
            check_vec("clr_addr", 32'(bus.addr_w), 32'(i));
            check_vec("clr_busy", 32'(bus.busy), 32'd1);
            check_vec("clr_din",  32'(bus.din), 32'd0);
            if (i == 10) set_lvl(4'b1000);
            if (i == 11) set_lvl(4'b0000);
            if (i == 30) bus.clr_req = 1'b1;
            if (i == 31) bus.clr_req = 1'b0;
            step_clk();
        end
        check_pen("after_clr", 5, 3);

        // 6. reset in the middle of a sweep
        bus.clr_req = 1'b1;
        step_clk();
        bus.clr_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check_vec("pre_rst_addr", 32'(bus.addr_w), 32'(i));
            step_clk();
        end
        check_vec("pre_rst_addr20", 32'(bus.addr_w), 32'd20);
        reset = 1'b1;
        step_clk();
        reset = 1'b0;
        check_vec("midrst_pen_x", 32'(bus.pen_x), 32'd0);
        check_vec("midrst_pen_y", 32'(bus.pen_y), 32'd0);
        check_sweep("sweep2");
        check_pen("draw_after_rst", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
